// File: rtl/led_rate_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : led_rate_ctrl
// Brief   : debounced speed/pause buttons driving a one-cycle LED tick enable
// Revision: 1.0
// ============================================================================
module led_rate_ctrl #(
  parameter int BASE_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_speed,
  input  logic       btn_pause,
  output logic       tick,
  output logic [1:0] speed,
  output logic       paused
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int DW = $clog2(BASE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // One extra bit so a power-of-two BASE_DIV is representable at speed 0
  localparam logic [DW:0]   BASE     = (DW+1)'(BASE_DIV);

  // Bit 0 is the speed button, bit 1 the pause button
  logic [1:0]          btn_raw;
  logic [1:0]          s1_q, s1_d, s2_q, s2_d;
  logic [1:0]          db_q, db_d;
  logic [1:0][CW-1:0]  cnt_q, cnt_d;
  logic [1:0]          press;
  logic [1:0]          speed_q, speed_d;
  logic                paused_q, paused_d;
  logic                tick_q, tick_d;
  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic [DW:0]         period;
  logic                terminal;

  assign btn_raw = {btn_pause, btn_speed};

  always_comb begin
    s1_d  = btn_raw;
    s2_d  = s1_q;
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign press    = db_d & ~db_q;
  assign period   = BASE >> speed_q;
  assign terminal = ({1'b0, div_cnt_q} == (period - (DW+1)'(1)));

  // A press on either button restarts the divider and suppresses any tick due
  always_comb begin
    speed_d   = speed_q;
    paused_d  = paused_q;
    tick_d    = 1'b0;
    div_cnt_d = div_cnt_q + DW'(1);
    if (press[0]) speed_d  = speed_q + 2'd1;
    if (press[1]) paused_d = ~paused_q;
    if ((|press) || paused_q) begin
      div_cnt_d = '0;
    end else if (terminal) begin
      tick_d    = 1'b1;
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      cnt_q     <= '0;
      speed_q   <= '0;
      paused_q  <= 1'b0;
      tick_q    <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      speed_q   <= speed_d;
      paused_q  <= paused_d;
      tick_q    <= tick_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tick   = tick_q;
  assign speed  = speed_q;
  assign paused = paused_q;

endmodule
`default_nettype wire

// File: tb/tb_led_rate_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_led_rate_ctrl
// Brief   : scenario tasks plus random buttons against a window/edge-count model
// Revision: 1.0
// ============================================================================
module tb_led_rate_ctrl;

  localparam int BASE_DIV = 16;
  localparam int DEB      = 4;
  localparam logic [63:0] MASK = (64'd1 << DEB) - 64'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_speed = 1'b0;
  logic       btn_pause = 1'b0;
  logic       tick;
  logic [1:0] speed;
  logic       paused;

  int n_checks = 0;
  int n_errors = 0;

  led_rate_ctrl #(.BASE_DIV(BASE_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .btn_speed(btn_speed), .btn_pause(btn_pause),
    .tick(tick), .speed(speed), .paused(paused)
  );

  always #5 clk = ~clk;

  // Model: a level is accepted once the last DEB synchronized samples all
  // disagree with it; ticks come every 'period' edges since the last restart.
  logic [1:0]  m_raw1 = 2'b00, m_raw2 = 2'b00, m_db = 2'b00, m_speed = 2'b00;
  logic        m_paused = 1'b0, m_tick = 1'b0;
  logic [63:0] m_hist [2] = '{64'd0, 64'd0};
  int          m_edge = 0, m_restart = 0;

  always @(posedge clk) begin : model
    logic [63:0] hn;
    logic [1:0]  db_n, pr;
    int          period;
    if (rst) begin
      m_db <= 2'b00; m_speed <= 2'b00; m_paused <= 1'b0; m_tick <= 1'b0;
      m_edge <= 0; m_restart <= 0; m_hist[0] <= 64'd0; m_hist[1] <= 64'd0;
    end else begin
      db_n = m_db;
      for (int i = 0; i < 2; i++) begin
        hn = {m_hist[i][62:0], m_raw2[i]};
        m_hist[i] <= hn;
        if ((hn & MASK) == (m_db[i] ? 64'd0 : MASK)) db_n[i] = ~m_db[i];
      end
      pr = db_n & ~m_db;
      m_db <= db_n;
      period = BASE_DIV >> m_speed;
      m_edge <= m_edge + 1;
      if (pr != 2'b00) begin
        if (pr[0]) m_speed  <= m_speed + 2'd1;
        if (pr[1]) m_paused <= ~m_paused;
        m_tick <= 1'b0; m_restart <= m_edge + 1;
      end else if (m_paused) begin
        m_tick <= 1'b0; m_restart <= m_edge + 1;
      end else if (m_edge + 1 - m_restart == period) begin
        m_tick <= 1'b1; m_restart <= m_edge + 1;
      end else begin
        m_tick <= 1'b0;
      end
    end
    m_raw1 <= rst ? 2'b00 : {btn_pause, btn_speed};
    m_raw2 <= rst ? 2'b00 : m_raw1;
  end

  task automatic test_reset();
    rst = 1'b1; btn_speed = 1'b0; btn_pause = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tick, speed, paused} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset: got tick=%b speed=%0d paused=%b, want all 0", tick, speed, paused);
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    int ticks = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      n_checks++;
      if ({tick, speed, paused} !== {m_tick, m_speed, m_paused}) begin
        n_errors++;
        $display("FAIL free_run k=%0d: got %b/%0d/%b want %b/%0d/%b", k, tick, speed, paused, m_tick, m_speed, m_paused);
      end
      if (tick === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks != 3) begin
      n_errors++;
      $display("FAIL free_run_count: got %0d ticks, want 3", ticks);
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 60; k++) begin
      btn_speed = (k < 20) && ((k / 2) % 2 == 0);
      @(negedge clk);
      n_checks++;
      if ({tick, speed, paused} !== {m_tick, m_speed, m_paused}) begin
        n_errors++;
        $display("FAIL bounce k=%0d: got %b/%0d/%b want %b/%0d/%b", k, tick, speed, paused, m_tick, m_speed, m_paused);
      end
    end
    n_checks++;
    if (speed !== 2'd0) begin
      n_errors++;
      $display("FAIL bounce_speed: got %0d, want 0", speed);
    end
  endtask

  task automatic test_speed_press();
    int first_spd = -1, first_tick = -1;
    for (int k = 1; k <= 40; k++) begin
      btn_speed = (k <= 10);
      @(negedge clk);
      n_checks++;
      if ({tick, speed, paused} !== {m_tick, m_speed, m_paused}) begin
        n_errors++;
        $display("FAIL speed_press k=%0d: got %b/%0d/%b want %b/%0d/%b", k, tick, speed, paused, m_tick, m_speed, m_paused);
      end
      if (speed === 2'd1 && first_spd < 0) first_spd = k;
      if (first_spd >= 0 && k > first_spd && tick === 1'b1 && first_tick < 0) first_tick = k;
    end
    btn_speed = 1'b0;
    n_checks++;
    if (first_spd != 6 || first_tick != 14) begin
      n_errors++;
      $display("FAIL speed_latency: got speed@%0d tick@%0d, want speed@6 tick@14", first_spd, first_tick);
    end
  endtask

  task automatic test_speed_wrap();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int p = 0; p < 4; p++) begin
      int last = -1, intv = -1;
      for (int k = 1; k <= 50; k++) begin
        btn_speed = (k <= 10);
        @(negedge clk);
        n_checks++;
        if ({tick, speed, paused} !== {m_tick, m_speed, m_paused}) begin
          n_errors++;
          $display("FAIL wrap p=%0d k=%0d: got %b/%0d/%b want %b/%0d/%b", p, k, tick, speed, paused, m_tick, m_speed, m_paused);
        end
        if (tick === 1'b1 && k > 6) begin
          if (last >= 0) intv = k - last;
          last = k;
        end
      end
      n_checks++;
      if (speed !== 2'((p + 1) % 4) || intv != (BASE_DIV >> ((p + 1) % 4))) begin
        n_errors++;
        $display("FAIL wrap_period p=%0d: got speed=%0d period=%0d, want speed=%0d period=%0d",
                 p, speed, intv, (p + 1) % 4, BASE_DIV >> ((p + 1) % 4));
      end
    end
  endtask

  task automatic test_pause();
    int ticks = 0, unp = -1, first_tick = -1;
    for (int k = 1; k <= 120; k++) begin
      btn_pause = (k <= 8);
      @(negedge clk);
      n_checks++;
      if ({tick, speed, paused} !== {m_tick, m_speed, m_paused}) begin
        n_errors++;
        $display("FAIL pause k=%0d: got %b/%0d/%b want %b/%0d/%b", k, tick, speed, paused, m_tick, m_speed, m_paused);
      end
      if (k > 20 && tick === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks != 0 || paused !== 1'b1) begin
      n_errors++;
      $display("FAIL pause_hold: got %0d ticks paused=%b, want 0 ticks paused=1", ticks, paused);
    end
    for (int k = 1; k <= 40; k++) begin
      btn_pause = (k <= 8);
      @(negedge clk);
      n_checks++;
      if ({tick, speed, paused} !== {m_tick, m_speed, m_paused}) begin
        n_errors++;
        $display("FAIL unpause k=%0d: got %b/%0d/%b want %b/%0d/%b", k, tick, speed, paused, m_tick, m_speed, m_paused);
      end
      if (paused === 1'b0 && unp < 0) unp = k;
      if (unp >= 0 && tick === 1'b1 && first_tick < 0) first_tick = k;
    end
    n_checks++;
    if (unp < 0 || first_tick - unp != 16) begin
      n_errors++;
      $display("FAIL unpause_latency: got %0d cycles, want 16", first_tick - unp);
    end
  endtask

  task automatic test_pause_on_terminal();
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (tick === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL terminal_wait: got no tick within 40 cycles, want one");
    end
    repeat (10) @(negedge clk);
    // Press lands 6 edges later, which is the next terminal-count edge
    for (int k = 1; k <= 60; k++) begin
      btn_pause = (k <= 10) || (k > 30 && k <= 38);
      @(negedge clk);
      n_checks++;
      if ({tick, speed, paused} !== {m_tick, m_speed, m_paused}) begin
        n_errors++;
        $display("FAIL terminal k=%0d: got %b/%0d/%b want %b/%0d/%b", k, tick, speed, paused, m_tick, m_speed, m_paused);
      end
      if (k == 6) begin
        n_checks++;
        if (tick !== 1'b0 || paused !== 1'b1) begin
          n_errors++;
          $display("FAIL terminal_press: got tick=%b paused=%b, want tick=0 paused=1", tick, paused);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int first_tick = -1;
    for (int k = 1; k <= 40; k++) begin
      btn_speed = (k <= 8) || (k > 20 && k <= 28);
      btn_pause = (k <= 8);
      @(negedge clk);
      n_checks++;
      if ({tick, speed, paused} !== {m_tick, m_speed, m_paused}) begin
        n_errors++;
        $display("FAIL mid_reset_setup k=%0d: got %b/%0d/%b want %b/%0d/%b", k, tick, speed, paused, m_tick, m_speed, m_paused);
      end
    end
    n_checks++;
    if (speed !== 2'd2 || paused !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset_pre: got speed=%0d paused=%b, want speed=2 paused=1", speed, paused);
    end
    btn_speed = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; btn_speed = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({tick, speed, paused} !== 4'b0000) begin
      n_errors++;
      $display("FAIL mid_reset: got tick=%b speed=%0d paused=%b, want all 0", tick, speed, paused);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_checks++;
      if ({tick, speed, paused} !== {m_tick, m_speed, m_paused}) begin
        n_errors++;
        $display("FAIL mid_reset_run k=%0d: got %b/%0d/%b want %b/%0d/%b", k, tick, speed, paused, m_tick, m_speed, m_paused);
      end
      if (tick === 1'b1 && first_tick < 0) first_tick = k;
    end
    n_checks++;
    if (first_tick != 16 || speed !== 2'd0) begin
      n_errors++;
      $display("FAIL mid_reset_tick: got tick@%0d speed=%0d, want tick@16 speed=0", first_tick, speed);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) btn_speed = ~btn_speed;
      if ($urandom_range(0, 6) == 0) btn_pause = ~btn_pause;
      @(negedge clk);
      n_checks++;
      if ({tick, speed, paused} !== {m_tick, m_speed, m_paused}) begin
        n_errors++;
        $display("FAIL random k=%0d: got %b/%0d/%b want %b/%0d/%b", k, tick, speed, paused, m_tick, m_speed, m_paused);
      end
    end
    btn_speed = 1'b0; btn_pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_bounce();
    test_speed_press();
    test_speed_wrap();
    test_pause();
    test_pause_on_terminal();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
